// File: rtl/button_conditioner.sv
// Button conditioner: 2-flop synchronizer, per-button debounce and a single-cycle press strobe.
// Define BUTTON_REPEAT_EN to add per-button auto-repeat on the buttons selected by REPEAT_MASK.
module button_conditioner #(
  parameter int                N_BTN         = 6,
  parameter int                DEBOUNCE      = 50000,
  parameter int                REPEAT_DELAY  = 10000000,
  parameter int                REPEAT_PERIOD = 2500000,
  parameter logic [N_BTN-1:0]  REPEAT_MASK   = 6'b001111
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_pulse
);

  localparam logic [15:0] DB_MAX = 16'(DEBOUNCE - 1);

  logic [N_BTN-1:0] sync1_q;
  logic [N_BTN-1:0] sync2_q;
  logic [N_BTN-1:0] level_q;
  logic [N_BTN-1:0] level_d;
  logic [N_BTN-1:0] pulse_q;
  logic [N_BTN-1:0] pulse_d;
  logic [N_BTN-1:0] press_s;
  logic [15:0]      cnt_q [N_BTN];
  logic [15:0]      cnt_d [N_BTN];

  // Two-stage synchronizer for the asynchronous pad inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= {N_BTN{1'b0}};
      sync2_q <= {N_BTN{1'b0}};
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
    end
  end

  // Stability counters: count while the synchronized value disagrees, accept at DEBOUNCE-1.
  always_comb begin
    level_d = level_q;
    for (int i = 0; i < N_BTN; i++) begin
      cnt_d[i] = 16'd0;
      if (sync2_q[i] == level_q[i]) begin
        cnt_d[i] = 16'd0;
      end else if (cnt_q[i] >= DB_MAX) begin
        level_d[i] = sync2_q[i];
        cnt_d[i]   = 16'd0;
      end else begin
        cnt_d[i] = cnt_q[i] + 16'd1;
      end
    end
  end

  assign press_s = level_d & ~level_q;

`ifdef BUTTON_REPEAT_EN
  localparam logic [1:0]  ST_IDLE   = 2'd0;
  localparam logic [1:0]  ST_DELAY  = 2'd1;
  localparam logic [1:0]  ST_REPEAT = 2'd2;
  localparam logic [31:0] RD_MAX    = 32'(REPEAT_DELAY - 1);
  localparam logic [31:0] RP_MAX    = 32'(REPEAT_PERIOD - 1);

  logic [N_BTN-1:0] rep_s;

  for (genvar g = 0; g < N_BTN; g++) begin : g_rep
    if (REPEAT_MASK[g]) begin : g_fsm
      logic [1:0]  st_q;
      logic [1:0]  st_d;
      logic [31:0] rc_q;
      logic [31:0] rc_d;
      logic        fire_s;

      // Repeat FSM; looking at level_d keeps a pulse out of the cycle the level reads 0.
      always_comb begin
        st_d   = st_q;
        rc_d   = rc_q;
        fire_s = 1'b0;
        if (!level_d[g]) begin
          st_d = ST_IDLE;
          rc_d = 32'd0;
        end else begin
          case (st_q)
            ST_IDLE: begin
              if (press_s[g]) begin
                st_d = ST_DELAY;
                rc_d = 32'd0;
              end else begin
                rc_d = 32'd0;
              end
            end
            ST_DELAY: begin
              if (rc_q >= RD_MAX) begin
                st_d   = ST_REPEAT;
                rc_d   = 32'd0;
                fire_s = 1'b1;
              end else begin
                rc_d = rc_q + 32'd1;
              end
            end
            ST_REPEAT: begin
              if (rc_q >= RP_MAX) begin
                rc_d   = 32'd0;
                fire_s = 1'b1;
              end else begin
                rc_d = rc_q + 32'd1;
              end
            end
            default: begin
              st_d = ST_IDLE;
              rc_d = 32'd0;
            end
          endcase
        end
      end

      // Repeat state registers.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          st_q <= ST_IDLE;
          rc_q <= 32'd0;
        end else begin
          st_q <= st_d;
          rc_q <= rc_d;
        end
      end

      assign rep_s[g] = fire_s;
    end else begin : g_none
      assign rep_s[g] = 1'b0;
    end
  end

  assign pulse_d = press_s | rep_s;
`else
  assign pulse_d = press_s;
`endif

  // Debounced level, counters and registered strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_q <= {N_BTN{1'b0}};
      pulse_q <= {N_BTN{1'b0}};
      for (int i = 0; i < N_BTN; i++) begin
        cnt_q[i] <= 16'd0;
      end
    end else begin
      level_q <= level_d;
      pulse_q <= pulse_d;
      for (int i = 0; i < N_BTN; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign btn_level = level_q;
  assign btn_pulse = pulse_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Randomized bench for button_conditioner against a window-based behavioural model.
// Build with or without BUTTON_REPEAT_EN; the model follows the same macro.
module tb_button_conditioner;
  localparam int N  = 6;
  localparam int DB = 4;
  localparam int RD = 20;
  localparam int RP = 5;
`ifdef BUTTON_REPEAT_EN
  localparam logic [5:0] RMASK = 6'b001111;
`else
  localparam logic [5:0] RMASK = 6'b000000;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] btn_raw;
  logic [5:0] btn_level;
  logic [5:0] btn_pulse;

  int checks = 0;
  int errors = 0;

  logic [5:0] samp [0:DB+1];
  logic [5:0] m_level;
  logic [5:0] m_pulse;
  int         hold [N];

  button_conditioner #(
    .N_BTN(N), .DEBOUNCE(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .REPEAT_MASK(6'b001111)
  ) dut (
    .clk(clk), .rst(rst), .btn_raw(btn_raw), .btn_level(btn_level), .btn_pulse(btn_pulse)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k <= DB + 1; k++) samp[k] = 6'd0;
    m_level = 6'd0;
    m_pulse = 6'd0;
    for (int b = 0; b < N; b++) hold[b] = 0;
  endtask

  // A level flips once the last DB synchronized samples all agree on the other value.
  task automatic model_edge(input logic [5:0] raw);
    logic [5:0] prev;
    logic       v;
    bit         stable;
    for (int k = DB + 1; k > 0; k--) samp[k] = samp[k-1];
    samp[0] = raw;
    prev = m_level;
    for (int b = 0; b < N; b++) begin
      v = samp[2][b];
      stable = 1'b1;
      for (int k = 2; k <= DB + 1; k++) if (samp[k][b] != v) stable = 1'b0;
      if (stable && v != m_level[b]) m_level[b] = v;
    end
    m_pulse = 6'd0;
    for (int b = 0; b < N; b++) begin
      if (!m_level[b]) hold[b] = 0;
      else if (!prev[b]) begin
        hold[b] = 0;
        m_pulse[b] = 1'b1;
      end else begin
        hold[b]++;
        if (RMASK[b] && hold[b] >= RD && ((hold[b] - RD) % RP) == 0) m_pulse[b] = 1'b1;
      end
    end
  endtask

  task automatic step(input logic [5:0] raw, input string tag);
    @(negedge clk);
    btn_raw = raw;
    @(posedge clk);
    #1;
    model_edge(raw);
    check_eq({tag, "_lvl"}, 32'(btn_level), 32'(m_level));
    check_eq({tag, "_pls"}, 32'(btn_pulse), 32'(m_pulse));
  endtask

  // Asynchronous reset: outputs must clear before any clock edge.
  task automatic async_reset(input string tag);
    #2;
    rst = 1'b1;
    #1;
    check_eq({tag, "_rst_lvl"}, 32'(btn_level), 32'd0);
    check_eq({tag, "_rst_pls"}, 32'(btn_pulse), 32'd0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int npulse;
    int dur [N];
    logic [5:0] rv;

    rst = 1'b1;
    btn_raw = 6'h3F;
    model_reset();
    #12;
    check_eq("reset_lvl", 32'(btn_level), 32'd0);
    check_eq("reset_pls", 32'(btn_pulse), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // All buttons held through reset: one press pulse at cycle 6.
    for (int c = 1; c <= 10; c++) begin
      step(6'h3F, "held");
      if (c == 6) begin
        check_eq("held_pulse6", 32'(btn_pulse), 32'h3F);
        check_eq("held_level6", 32'(btn_level), 32'h3F);
      end else if (c < 6) begin
        check_eq("held_nolvl", 32'(btn_level), 32'h0);
      end else begin
        check_eq("held_nopls", 32'(btn_pulse), 32'h0);
      end
    end
    async_reset("after_held");

    // Glitch shorter than the debounce window.
    npulse = 0;
    for (int c = 1; c <= 12; c++) begin
      step((c <= 3) ? 6'h10 : 6'h00, "glitch");
      if (btn_level != 6'd0 || btn_pulse != 6'd0) npulse++;
    end
    check_eq("glitch_quiet", 32'(npulse), 32'd0);

    // Simultaneous press of up and new, then release.
    for (int c = 1; c <= 8; c++) begin
      step(6'h21, "simul");
      if (c == 6) check_eq("simul_pulse6", 32'(btn_pulse), 32'h21);
    end
    npulse = 0;
    for (int c = 1; c <= 8; c++) begin
      step(6'h00, "release");
      if (btn_pulse != 6'd0) npulse++;
      if (c == 5) check_eq("release_lvl5", 32'(btn_level), 32'h21);
      if (c == 6) check_eq("release_lvl6", 32'(btn_level), 32'h00);
    end
    check_eq("release_nopulse", 32'(npulse), 32'd0);

    // Long hold on left: repeat pulses only when the feature is built in.
    async_reset("pre_left");
    npulse = 0;
    for (int c = 1; c <= 60; c++) begin
      step(6'h02, "left");
      if (btn_pulse[1]) npulse++;
      if (c == 6) check_eq("left_pulse6", 32'(btn_pulse), 32'h02);
`ifdef BUTTON_REPEAT_EN
      if (c == 26 || c == 31 || c == 36) check_eq("left_repeat", 32'(btn_pulse), 32'h02);
      if (c == 25 || c == 27) check_eq("left_gap", 32'(btn_pulse), 32'h00);
`endif
    end
`ifdef BUTTON_REPEAT_EN
    check_eq("left_count", 32'(npulse), 32'd8);
`else
    check_eq("left_count", 32'(npulse), 32'd1);
`endif
    async_reset("mid_repeat");
    npulse = 0;
    for (int c = 1; c <= 60; c++) begin
      step(6'h10, "guess");
      if (btn_pulse[4]) npulse++;
    end
    check_eq("guess_count", 32'(npulse), 32'd1);
    for (int c = 1; c <= 8; c++) step(6'h00, "guess_rel");

    // Reset in the middle of a debounce on right.
    for (int c = 1; c <= 3; c++) step(6'h04, "mid_db");
    async_reset("mid_db");
    npulse = 0;
    for (int c = 1; c <= 10; c++) begin
      step(6'h00, "mid_db_after");
      if (btn_pulse != 6'd0) npulse++;
    end
    check_eq("mid_db_nopulse", 32'(npulse), 32'd0);

    // Random holds of mixed length, with occasional asynchronous resets.
    for (int b = 0; b < N; b++) dur[b] = 0;
    rv = 6'd0;
    for (int c = 0; c < 2500; c++) begin
      for (int b = 0; b < N; b++) begin
        if (dur[b] == 0) begin
          rv[b] = 1'($urandom_range(0, 1));
          dur[b] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 60))
                                               : int'($urandom_range(1, 7));
        end
        dur[b]--;
      end
      step(rv, "rand");
      if ($urandom_range(0, 399) == 0) async_reset("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter N_BTN, default 6, SHALL set the number of buttons; bit order is up, left, right, down, guess, new (bit 0 = up).
REQ-002 Parameter DEBOUNCE, default 50000, SHALL set the number of consecutive stable cycles required to accept a level change (legal range 2..65535).
REQ-003 Parameter REPEAT_DELAY, default 10000000, SHALL set the hold time in cycles before the first auto-repeat pulse.
REQ-004 Parameter REPEAT_PERIOD, default 2500000, SHALL set the interval in cycles between subsequent auto-repeat pulses.
REQ-005 Parameter REPEAT_MASK, default 6'b001111, SHALL select which buttons auto-repeat (directional buttons only by default).
REQ-006 Port clk, input, 1: single clock for all logic.
REQ-007 Port rst, input, 1: reset, asynchronous, active-high.
REQ-008 Port btn_raw, input, N_BTN: asynchronous pad-level button inputs, active-high.
REQ-009 Port btn_level, output, N_BTN: debounced button state.
REQ-010 Port btn_pulse, output, N_BTN: one-cycle press/repeat strobes, consumed directly by the game core's btn_* inputs.

Function
REQ-011 Each btn_raw bit SHALL pass through a 2-flop synchronizer before any other use.
REQ-012 Each button SHALL have an independent 16-bit stability counter, cleared whenever the synchronized value equals btn_level.
REQ-013 While the synchronized value differs from btn_level, the counter SHALL increment each cycle; on reaching DEBOUNCE-1, btn_level SHALL take the synchronized value on the next edge and the counter SHALL clear.
REQ-014 A raw change held constant SHALL appear on btn_level exactly DEBOUNCE+2 cycles after the first clk edge that samples it.
REQ-015 Any glitch shorter than DEBOUNCE cycles at synchronizer output SHALL NOT change btn_level; the counter restarts from 0 after the glitch.
REQ-016 btn_pulse[i] SHALL be 1 for exactly one cycle, in the same cycle btn_level[i] first reads 1 after a 0->1 transition.
REQ-017 Release (1->0 of btn_level) SHALL NOT generate a pulse.
REQ-018 Buttons SHALL be fully independent; simultaneous presses SHALL yield simultaneous pulses with no priority or masking.
REQ-019 The counter SHALL saturate, never wrap, and SHALL never exceed DEBOUNCE-1.

Reset
REQ-020 While rst is high, synchronizer flops, btn_level, btn_pulse, all counters and repeat state SHALL be 0, asynchronously.
REQ-021 After rst deasserts with a button already held, a single press pulse SHALL follow DEBOUNCE+2 cycles later (held button treated as new press).
REQ-022 Reset asserted mid-debounce or mid-repeat SHALL abandon the operation with no pulse emitted.

Configuration
REQ-023 Macro BUTTON_REPEAT_EN SHALL compile in auto-repeat; without it, repeat counters SHALL not exist and REPEAT_* parameters SHALL be ignored.
REQ-024 With BUTTON_REPEAT_EN, for each bit set in REPEAT_MASK, a per-button repeat FSM SHALL have states IDLE, DELAY, REPEAT.
REQ-025 IDLE->DELAY on press pulse (counter cleared); DELAY->REPEAT after REPEAT_DELAY cycles with btn_level high, emitting one pulse; in REPEAT, one pulse SHALL be emitted every REPEAT_PERIOD cycles.
REQ-026 Any state SHALL return to IDLE in the cycle btn_level reads 0; no pulse SHALL be emitted in that cycle.
REQ-027 Repeat pulses SHALL be OR-ed into btn_pulse and SHALL remain one cycle wide; unmasked bits SHALL behave as without the macro.

Verification (run with DEBOUNCE=4, REPEAT_DELAY=20, REPEAT_PERIOD=5)
REQ-028 rst high, btn_raw=6'h3F -> btn_level=0, btn_pulse=0; after rst drops, btn_level=6'h3F and btn_pulse=6'h3F for one cycle at cycle 6.
REQ-029 btn_raw[4] high for 3 cycles then low -> btn_level and btn_pulse stay 0 throughout.
REQ-030 btn_raw[0] and btn_raw[5] rise in the same cycle and are held -> single-cycle btn_pulse=6'h21 at cycle 6; release -> no pulse, btn_level returns to 0 after 6 cycles.
REQ-031 With BUTTON_REPEAT_EN, hold btn_raw[1] for 60 cycles -> pulses at cycles 6, 26, 31, 36, 41, ...; hold btn_raw[4] -> exactly one pulse.
REQ-032 Without BUTTON_REPEAT_EN, same 60-cycle hold on btn_raw[1] -> exactly one pulse at cycle 6.
REQ-033 rst pulsed at cycle 3 of a debounce on btn_raw[2] -> no pulse; outputs 0 immediately, without waiting for a clk edge.
